// File: rtl/uart_pkg.sv
// Shared UART types and elaboration-time helpers used by the receiver,
// the transmitter and the common baud tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        PARITY    = 3'd4,
        STOP      = 3'd5
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int calc_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every P_DIV clocks; a restart
// zeroes the count so the next tick lands exactly P_DIV cycles later.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int P_DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (clog2(P_DIV) < 1) ? 1 : clog2(P_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and registered tick (tick mirrors the count reaching P_DIV-1)
    always_comb begin
        cnt_d = cnt_q;
        if (i_restart) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CW'(P_DIV - 1)) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == CW'(P_DIV - 1));
    end

    // Divider state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: synchronises the line, majority-votes each bit
// at mid-cell and reports good words, framing errors and parity errors as pulses.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK     = 50_000_000,
    parameter int P_UART_BUADRATE  = 9600,
    parameter int P_UART_DATAWIDTH = 8,
    parameter int P_UART_STOPWIDTH = 1,
    parameter int P_OVERSAMPLE     = 16,
    parameter int P_PARITY         = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_uart_rx,
    output logic [P_UART_DATAWIDTH-1:0] o_user_rx_data,
    output logic                        o_user_rx_valid,
    output logic                        o_frame_err,
    output logic                        o_parity_err,
    output logic                        o_rx_busy
);

    localparam int D  = calc_div(P_SYSTEM_CLK, P_UART_BUADRATE, P_OVERSAMPLE);
    localparam int M  = P_OVERSAMPLE / 2;
    localparam int W  = P_UART_DATAWIDTH;
    localparam int IW = clog2(P_OVERSAMPLE);
    localparam int BW = (clog2(W) < 1) ? 1 : clog2(W);

    logic          sync1_q, rx_s, rx_d;
    uart_state_e   state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [1:0]    vote_q, vote_d;
    logic [W-1:0]  shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic          frame_err_q, frame_err_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          busy_q, busy_d;

    logic fall_s, restart_s, tick_s, in_frame_s, resolve_s, cell_end_s, maj_s, stop_bad_s;

    assign fall_s     = rx_d & ~rx_s;
    assign restart_s  = (state_q == IDLE) & fall_s;
    assign in_frame_s = state_q inside {START, DATA, PARITY, STOP};
    assign resolve_s  = tick_s & (idx_q == IW'(M + 1));
    assign cell_end_s = tick_s & (idx_q == IW'(P_OVERSAMPLE - 1));
    // Votes at M-1 and M are stored; the third vote is the live sample at M+1
    assign maj_s      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    assign stop_bad_s = frame_err_q | ~maj_s;

    uart_baud_tick #(.P_DIV(D)) u_tick (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_restart (restart_s),
        .o_tick    (tick_s)
    );

    // Next-state, sampling, deserialisation and result issue
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bit_d       = bit_q;
        stop_d      = stop_q;
        vote_d      = vote_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;

        if (in_frame_s && tick_s) begin
            idx_d = cell_end_s ? {IW{1'b0}} : idx_q + IW'(1);
            if (idx_q == IW'(M - 1)) begin
                vote_d[0] = rx_s;
            end else if (idx_q == IW'(M)) begin
                vote_d[1] = rx_s;
            end else begin
                vote_d = vote_q;
            end
        end else begin
            idx_d = idx_q;
        end

        case (state_q)
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            IDLE: begin
                if (fall_s) begin
                    state_d     = START;
                    idx_d       = {IW{1'b0}};
                    bit_d       = {BW{1'b0}};
                    stop_d      = 1'b0;
                    par_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (resolve_s && maj_s) begin
                    state_d = IDLE;
                end else if (cell_end_s) begin
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (resolve_s) begin
                    shift_d = {maj_s, shift_q[W-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (cell_end_s) begin
                    if (bit_q == BW'(W - 1)) begin
                        bit_d   = {BW{1'b0}};
                        state_d = (P_PARITY != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    bit_d = bit_q;
                end
            end
            PARITY: begin
                // Mismatch when the 1s count over data+parity has the wrong oddness
                if (resolve_s) begin
                    par_err_d = ((^shift_q) ^ maj_s) != (P_PARITY == PAR_ODD);
                end else begin
                    par_err_d = par_err_q;
                end
                if (cell_end_s) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (resolve_s) begin
                    if (stop_q == 1'(P_UART_STOPWIDTH - 1)) begin
                        valid_d = ~stop_bad_s & ~par_err_q;
                        data_d  = (~stop_bad_s & ~par_err_q) ? shift_q : data_q;
                        ferr_d  = stop_bad_s;
                        perr_d  = par_err_q;
                        state_d = rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        frame_err_d = stop_bad_s;
                    end
                end else if (cell_end_s) begin
                    stop_d = 1'b1;
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase

        busy_d = state_d inside {START, DATA, PARITY, STOP};
    end

    // State, synchroniser and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= 1'b1;
            rx_s        <= 1'b1;
            rx_d        <= 1'b1;
            state_q     <= WAIT_HIGH;
            idx_q       <= {IW{1'b0}};
            bit_q       <= {BW{1'b0}};
            stop_q      <= 1'b0;
            vote_q      <= 2'b00;
            shift_q     <= {W{1'b0}};
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= {W{1'b0}};
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= i_uart_rx;
            rx_s        <= sync1_q;
            rx_d        <= rx_s;
            state_q     <= state_d;
            idx_q       <= idx_d;
            bit_q       <= bit_d;
            stop_q      <= stop_d;
            vote_q      <= vote_d;
            shift_q     <= shift_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
            busy_q      <= busy_d;
        end
    end

    assign o_user_rx_data  = data_q;
    assign o_user_rx_valid = valid_q;
    assign o_frame_err     = ferr_q;
    assign o_parity_err    = perr_q;
    assign o_rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench: a no-parity receiver and an even-parity receiver, driven with
// hand-built frames at 160 clocks per bit.
module tb_uart_rx_oversample;

    localparam int W   = 8;
    localparam int BIT = 160;
    localparam int LAT = 9 * 160 + (8 + 2) * 10 + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_a = 1'b1;
    logic         rx_b = 1'b1;
    logic [W-1:0] data_a, data_b;
    logic         valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b, busy_a, busy_b;

    always #5 clk = ~clk;

    uart_rx_oversample #(
        .P_SYSTEM_CLK(1_600_000), .P_UART_BUADRATE(10_000), .P_UART_DATAWIDTH(8),
        .P_UART_STOPWIDTH(1), .P_OVERSAMPLE(16), .P_PARITY(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_a),
        .o_user_rx_data(data_a), .o_user_rx_valid(valid_a),
        .o_frame_err(ferr_a), .o_parity_err(perr_a), .o_rx_busy(busy_a)
    );

    uart_rx_oversample #(
        .P_SYSTEM_CLK(1_600_000), .P_UART_BUADRATE(10_000), .P_UART_DATAWIDTH(8),
        .P_UART_STOPWIDTH(1), .P_OVERSAMPLE(16), .P_PARITY(2)
    ) dut_par (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(rx_b),
        .o_user_rx_data(data_b), .o_user_rx_valid(valid_b),
        .o_frame_err(ferr_b), .o_parity_err(perr_b), .o_rx_busy(busy_b)
    );

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    int va_cnt = 0, fa_cnt = 0, pa_cnt = 0, va_cyc = 0;
    int vb_cnt = 0, fb_cnt = 0, pb_cnt = 0;
    int t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (valid_a) begin
            va_cnt <= va_cnt + 1;
            va_cyc <= cyc;
        end
        if (ferr_a)  fa_cnt <= fa_cnt + 1;
        if (perr_a)  pa_cnt <= pa_cnt + 1;
        if (valid_b) vb_cnt <= vb_cnt + 1;
        if (ferr_b)  fb_cnt <= fb_cnt + 1;
        if (perr_b)  pb_cnt <= pb_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One frame: start, LSB-first data, optional parity, one stop bit.
    // glitch_bit >= 0 pulses that data cell high for offsets 80..89.
    task automatic send_frame(input bit sel, input logic [8:0] data, input bit has_par,
                              input logic par_bit, input logic stop_val, input int glitch_bit);
        t_start = cyc;
        drive(sel, 1'b0);
        hold(BIT);
        for (int i = 0; i < W; i++) begin
            drive(sel, data[i]);
            if (i == glitch_bit) begin
                hold(80);
                drive(sel, 1'b1);
                hold(10);
                drive(sel, data[i]);
                hold(70);
            end else begin
                hold(BIT);
            end
        end
        if (has_par) begin
            drive(sel, par_bit);
            hold(BIT);
        end
        drive(sel, stop_val);
        hold(BIT);
    endtask

    initial begin
        @(negedge clk);
        hold(5);
        check("rst_data",  32'(data_a),  32'h00);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_ferr",  32'(ferr_a),  32'h0);
        check("rst_perr",  32'(perr_a),  32'h0);
        check("rst_busy",  32'(busy_a),  32'h0);
        rst = 1'b0;
        hold(20);

        // 0x55 8N1: data, latency from the line edge (2 sync stages + LAT)
        send_frame(1'b0, 9'h055, 1'b0, 1'b0, 1'b1, -1);
        hold(20);
        check("t1_valid_cnt", 32'(va_cnt), 32'd1);
        check("t1_data",      32'(data_a), 32'h55);
        check("t1_latency",   32'(va_cyc), 32'(t_start + 2 + LAT));
        check("t1_ferr_cnt",  32'(fa_cnt), 32'd0);
        check("t1_perr_cnt",  32'(pa_cnt), 32'd0);
        check("t1_busy",      32'(busy_a), 32'h0);

        // False start: 50-clock low pulse
        drive(1'b0, 1'b0);
        hold(50);
        drive(1'b0, 1'b1);
        hold(200);
        check("t2_valid_cnt", 32'(va_cnt), 32'd1);
        check("t2_ferr_cnt",  32'(fa_cnt), 32'd0);
        check("t2_busy",      32'(busy_a), 32'h0);
        send_frame(1'b0, 9'h0A3, 1'b0, 1'b0, 1'b1, -1);
        hold(20);
        check("t2_valid_cnt2", 32'(va_cnt), 32'd2);
        check("t2_data",       32'(data_a), 32'hA3);

        // Framing error followed by a held-low line
        send_frame(1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, -1);
        hold(480);
        check("t3_ferr_cnt",  32'(fa_cnt), 32'd1);
        check("t3_valid_cnt", 32'(va_cnt), 32'd2);
        check("t3_perr_cnt",  32'(pa_cnt), 32'd0);
        check("t3_data_kept", 32'(data_a), 32'hA3);
        check("t3_busy",      32'(busy_a), 32'h0);
        drive(1'b0, 1'b1);
        hold(40);
        send_frame(1'b0, 9'h012, 1'b0, 1'b0, 1'b1, -1);
        hold(20);
        check("t3_valid_cnt2", 32'(va_cnt), 32'd3);
        check("t3_data2",      32'(data_a), 32'h12);
        check("t3_ferr_cnt2",  32'(fa_cnt), 32'd1);

        // Even parity on the second receiver
        send_frame(1'b1, 9'h007, 1'b1, 1'b1, 1'b1, -1);
        hold(20);
        check("t4_valid_cnt", 32'(vb_cnt), 32'd1);
        check("t4_data",      32'(data_b), 32'h07);
        check("t4_perr_cnt",  32'(pb_cnt), 32'd0);
        send_frame(1'b1, 9'h007, 1'b1, 1'b0, 1'b1, -1);
        hold(20);
        check("t4_perr_cnt2",  32'(pb_cnt), 32'd1);
        check("t4_valid_cnt2", 32'(vb_cnt), 32'd1);
        check("t4_ferr_cnt",   32'(fb_cnt), 32'd0);
        check("t4_data_kept",  32'(data_b), 32'h07);

        // Reset during data bit 3 of 0x3C (bits 0..2 = 0,0,1; bit 3 = 1)
        drive(1'b0, 1'b0);
        hold(BIT);
        drive(1'b0, 1'b0); hold(BIT);
        drive(1'b0, 1'b0); hold(BIT);
        drive(1'b0, 1'b1); hold(BIT);
        drive(1'b0, 1'b1); hold(80);
        drive(1'b0, 1'b0);
        rst = 1'b1;
        hold(3);
        check("t5_rst_data", 32'(data_a), 32'h00);
        check("t5_rst_busy", 32'(busy_a), 32'h0);
        check("t5_rst_flags", 32'({valid_a, ferr_a, perr_a}), 32'h0);
        rst = 1'b0;
        hold(20);
        drive(1'b0, 1'b1);
        hold(200);
        check("t5_valid_cnt", 32'(va_cnt), 32'd3);
        check("t5_ferr_cnt",  32'(fa_cnt), 32'd1);
        check("t5_data",      32'(data_a), 32'h00);
        check("t5_busy",      32'(busy_a), 32'h0);
        send_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1'b1, -1);
        hold(20);
        check("t5_valid_cnt2", 32'(va_cnt), 32'd4);
        check("t5_data2",      32'(data_a), 32'h3C);

        // 0x00 with a glitch over sample index 8 of bit 2
        send_frame(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 2);
        hold(20);
        check("t6_valid_cnt", 32'(va_cnt), 32'd5);
        check("t6_data",      32'(data_a), 32'h00);
        check("t6_ferr_cnt",  32'(fa_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
Oversampling UART receiver. It is the receive end of the link driven by the team's UART transmitter, and it slots into the UART drive wrapper as its receive path.
- Synchronises the asynchronous serial line and detects the start bit.
- Majority-votes each bit at mid-cell and deserialises LSB-first.
- Optionally checks parity and checks the stop bit(s).
- Presents each received word as a single-cycle valid pulse, and flags framing and parity errors separately.

Parameters:
P_SYSTEM_CLK, 50_000_000, clock frequency in Hz
P_UART_BUADRATE, 9600, line rate in baud
P_UART_DATAWIDTH, 8, data bits per frame (5..9)
P_UART_STOPWIDTH, 1, stop bits (1 or 2)
P_OVERSAMPLE, 16, samples per bit (>=8, even)
P_PARITY, 0, parity mode: 0 none, 1 odd, 2 even

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset
i_uart_rx  in  1  asynchronous serial line, idle high
o_user_rx_data  out  P_UART_DATAWIDTH  last good word
o_user_rx_valid  out  1  one-cycle pulse, good word on o_user_rx_data
o_frame_err  out  1  one-cycle pulse, a stop bit sampled 0
o_parity_err  out  1  one-cycle pulse, parity mismatch
o_rx_busy  out  1  high in START/DATA/PARITY/STOP

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - Both synchroniser flops 1.
  - State WAIT_HIGH; all counters 0.
- Synchroniser: 2-flop synchroniser on i_uart_rx, then one delay flop for edge detection. A falling edge is rx_d=1 and rx_s=0.
- Tick generator:
  - Divisor D = P_SYSTEM_CLK/(P_UART_BUADRATE*P_OVERSAMPLE), integer truncation.
  - Tick pulses every D cycles.
  - The divider is forced to 0 in the cycle the falling edge is detected, so the first tick comes D cycles later.
- Sample index: 0..P_OVERSAMPLE-1 per bit cell, incremented on each tick.
- Votes: taken at indices M-1, M, M+1, where M = P_OVERSAMPLE/2. The bit value is the majority of the three, resolved on the tick at index M+1.
- States:
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE.
  - IDLE: on a falling edge go to START; restart the divider and the sample index.
  - START: on vote resolve, a majority 1 is a false start: go to IDLE with no output. At index P_OVERSAMPLE-1 go to DATA.
  - DATA: shift the voted bit in LSB-first. After P_UART_DATAWIDTH bits go to PARITY if P_PARITY!=0, else to STOP.
  - PARITY: vote the parity bit. Mismatch is recorded; odd mode requires an odd count of 1s over data+parity, even mode an even count.
  - STOP: vote each stop bit. After resolving the last stop bit, issue the result in the next cycle (below).
- Result issue (one cycle after the last stop bit resolves):
  - Good frame (no framing or parity error): update o_user_rx_data and pulse o_user_rx_valid.
  - Any stop bit 0: pulse o_frame_err. Also pulse o_parity_err if parity mismatched. o_user_rx_data is not updated and valid is not pulsed.
  - Stop bits good but parity mismatched: pulse o_parity_err only.
- Next state after issue: IDLE if rx_s=1, else WAIT_HIGH (break/held-low line). Re-arming inside the stop cell is allowed; the next start edge must be a fresh falling edge.
- o_user_rx_data holds its value between valid pulses.
- Latency: valid rises (1+P_UART_DATAWIDTH+(P_PARITY!=0)+P_UART_STOPWIDTH-1)*P_OVERSAMPLE*D + (M+2)*D + 1 cycles after the edge-detect cycle.
- Reset mid-frame: abort, clear outputs, return to WAIT_HIGH. No pulse is emitted for the aborted frame.
- Reset dominates all other events in the same cycle.

Decomposition:
- Package uart_pkg holds:
  - the state enum (WAIT_HIGH, IDLE, START, DATA, PARITY, STOP);
  - parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - function calc_div(clk, baud, os) returning D;
  - function clog2.
- Sub-module uart_baud_tick: divider with synchronous restart input and tick output, shareable with the transmitter.

Test Plan:
Bench parameters: P_SYSTEM_CLK=1_600_000, P_UART_BUADRATE=10_000, P_OVERSAMPLE=16, so D=10 and bit period = 160 clocks.
1. Send 0x55 as 8N1 -> one valid pulse 1*160*... exactly 9*160+100+1=1541 cycles after edge detect; data=0x55; both error outputs 0; o_rx_busy low afterwards.
2. Drive the line low for 50 clocks, then high -> false start: no pulses, return to IDLE. A following 0xA3 frame is received correctly.
3. Send 0xFF with the stop bit driven 0, then hold the line low 480 clocks -> o_frame_err pulses once, no valid, data keeps its old value. No further pulses until the line goes high. A following 0x12 frame is received correctly.
4. With P_PARITY=2:
   - 0x07 with parity bit 1 -> valid, data=0x07.
   - 0x07 with parity bit 0 -> o_parity_err only.
5. Assert i_rst during data bit 3 of 0x3C, holding the line low through reset release -> all outputs 0 and no pulse. A subsequent full 0x3C frame after the line goes high is received correctly.
6. Send 0x00 with sample index 8 of bit 2 flipped high (a 10-clock glitch) -> the majority vote rejects it; valid with data=0x00.
